// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared PS/2 state encodings, command bytes and default timing
package ps2_host_tx_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ACK,
    ST_WAIT_IDLE
  } state_e;
  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;
  localparam int DEF_INHIBIT_CYCLES      = 6000;
  localparam int DEF_EDGE_TIMEOUT_CYCLES = 750000;
  localparam int DEF_FILTER_LEN          = 8;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: synchronize a raw PS/2 pad, debounce it and flag falling edges
module ps2_line_filter import ps2_host_tx_pkg::*; #(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic filt_o,
  output logic fe_o
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          filt_q;
  logic          fe_q;
  // filtered value flips after FILTER_LEN consecutive differing samples; fe pulses with the 1->0 flip
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt_q <= 1'b1;
      fe_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      fe_q   <= 1'b0;
      if (sync_q[1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_q <= sync_q[1];
        cnt_q  <= '0;
        fe_q   <= filt_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
  assign filt_o = filt_q;
  assign fe_o   = fe_q;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter driving open-drain clock/data pulls
module ps2_host_tx import ps2_host_tx_pkg::*; #(
  parameter int INHIBIT_CYCLES      = DEF_INHIBIT_CYCLES,
  parameter int EDGE_TIMEOUT_CYCLES = DEF_EDGE_TIMEOUT_CYCLES,
  parameter int FILTER_LEN          = DEF_FILTER_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       kclk_in,
  input  logic       kdata_in,
  output logic       kclk_drive_low,
  output logic       kdata_drive_low,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout
);
  localparam int CNT_MAX = (EDGE_TIMEOUT_CYCLES > INHIBIT_CYCLES) ? EDGE_TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    sh_q, sh_d;
  logic          kclk_q, kclk_d, kdata_q, kdata_d;
  logic          done_q, done_d, ack_q, ack_d, err_q, err_d;
  logic          kclk_f, kclk_fe, kdata_f, kdata_fe_unused;
  logic          in_frame, wd_hit;
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_kclk (
    .clk(clk), .reset(reset), .line_i(kclk_in), .filt_o(kclk_f), .fe_o(kclk_fe)
  );
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_kdata (
    .clk(clk), .reset(reset), .line_i(kdata_in), .filt_o(kdata_f), .fe_o(kdata_fe_unused)
  );
  assign in_frame = state_q inside {ST_REQ, ST_DATA, ST_PARITY, ST_STOP};
  assign wd_hit   = cnt_q == CW'(EDGE_TIMEOUT_CYCLES - 1);
  // next state: frame sequencing on filtered falling edges, with the edge watchdog overriding everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    kclk_d  = kclk_q;
    kdata_d = kdata_q;
    ack_d   = ack_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bit_d = '0;
        if (tx_valid && tx_ready) begin
          state_d = ST_INHIBIT;
          sh_d    = {~^tx_data, tx_data};
          cnt_d   = '0;
          kclk_d  = 1'b1;
        end
      end
      ST_INHIBIT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          state_d = ST_REQ;
          cnt_d   = '0;
          kclk_d  = 1'b0;
          kdata_d = 1'b1;
        end
      end
      default: begin
        cnt_d = kclk_fe ? '0 : cnt_q + CW'(1);
        bit_d = (kclk_fe && in_frame) ? bit_q + 4'd1 : bit_q;
        case (state_q)
          ST_REQ, ST_DATA: if (kclk_fe) begin
            kdata_d = ~sh_q[bit_q];
            state_d = (bit_q == 4'd8) ? ST_PARITY : ST_DATA;
          end
          ST_PARITY: if (kclk_fe) begin
            kdata_d = 1'b0;
            state_d = ST_STOP;
          end
          ST_STOP: if (kclk_fe) begin
            ack_d   = ~kdata_f;
            state_d = ST_ACK;
          end
          ST_ACK: state_d = kclk_f ? ST_WAIT_IDLE : ST_ACK;
          default: if (kclk_f && kdata_f) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        endcase
        if (!kclk_fe && wd_hit) begin
          state_d = ST_IDLE;
          kclk_d  = 1'b0;
          kdata_d = 1'b0;
          done_d  = 1'b0;
          err_d   = 1'b1;
        end
      end
    endcase
  end
  // state and registered line/status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      kclk_q  <= 1'b0;
      kdata_q <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      kclk_q  <= kclk_d;
      kdata_q <= kdata_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign kclk_drive_low  = kclk_q;
  assign kdata_drive_low = kdata_q;
  assign done            = done_q;
  assign err_timeout     = err_q;
  assign ack_ok          = done_q & ack_q;
  assign busy            = state_q != ST_IDLE;
  assign tx_ready        = (state_q == ST_IDLE) & ~done_q & ~err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed open-drain bus and device-model checks of ps2_host_tx
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic tx_ready, kclk_drive_low, kdata_drive_low, busy, done, ack_ok, err_timeout;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic kclk_line, kdata_line;
  int checks = 0, failures = 0, done_cnt = 0, err_cnt = 0;
  logic last_ack = 1'b0, busy_at_done = 1'b0, ready_after = 1'b0, pend = 1'b0;
  logic [10:0] bits;
  int t, prev_done, prev_err, hits;
  assign kclk_line  = ~(kclk_drive_low | dev_clk_low);
  assign kdata_line = ~(kdata_drive_low | dev_data_low);
  ps2_host_tx #(.INHIBIT_CYCLES(20), .EDGE_TIMEOUT_CYCLES(2000), .FILTER_LEN(4)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .kclk_in(kclk_line), .kdata_in(kdata_line), .kclk_drive_low(kclk_drive_low),
    .kdata_drive_low(kdata_drive_low), .busy(busy), .done(done), .ack_ok(ack_ok),
    .err_timeout(err_timeout)
  );
  always #10 clk = ~clk;
  // pulse monitor sampled on the inactive edge
  always @(negedge clk) begin
    if (pend) begin
      ready_after = tx_ready;
      pend = 1'b0;
    end
    if (done) begin
      done_cnt++;
      last_ack = ack_ok;
      busy_at_done = busy;
      pend = 1'b1;
    end
    if (err_timeout) err_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    check("ready_before_send", tx_ready, 1);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("ready_busy_after_accept", {tx_ready, busy}, 2'b01);
  endtask
  task automatic dev_frame(input bit ack, input int n, input bit glitch, output logic [10:0] b);
    int w = 0;
    b = '0;
    while (!(kclk_line && !kdata_line) && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("req_seen", w < 300, 1);
    b[0] = kdata_line;
    for (int k = 1; k <= n; k++) begin
      repeat (20) @(negedge clk);
      if (glitch && k == 3) begin
        dev_clk_low = 1'b1;
        repeat (3) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (10) @(negedge clk);
      end
      if (ack && k == 11) dev_data_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (40) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) b[k] = kdata_line;
    end
    if (ack && n == 11) begin
      repeat (20) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask
  task automatic finish_frame(input int prev, input logic exp_ack);
    int w = 0;
    while (done_cnt == prev && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    check("done_count", done_cnt - prev, 1);
    check("ack_ok", last_ack, exp_ack);
    check("busy_at_done", busy_at_done, 0);
    check("ready_after_done", ready_after, 1);
    check("lines_released", {kclk_drive_low, kdata_drive_low}, 2'b00);
  endtask
  initial begin
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_state", {tx_ready, busy, done, ack_ok, err_timeout, kclk_drive_low, kdata_drive_low}, 7'b1000000);
    // set-LEDs with ack, plus exact inhibit window timing
    prev_done = done_cnt;
    send(PS2_CMD_SET_LED);
    hits = (kclk_drive_low && !kdata_drive_low) ? 1 : 0;
    repeat (19) begin
      @(negedge clk);
      if (kclk_drive_low && !kdata_drive_low) hits++;
    end
    check("inhibit_cycles", hits, 20);
    @(negedge clk);
    check("req_lines", {kclk_drive_low, kdata_drive_low}, 2'b01);
    dev_frame(1'b1, 11, 1'b0, bits);
    check("bits_ed", bits, 11'h7DA);
    finish_frame(prev_done, 1'b1);
    // enable command, device does not ack
    prev_done = done_cnt;
    send(PS2_CMD_ENABLE);
    dev_frame(1'b0, 11, 1'b0, bits);
    check("bits_f4", bits, 11'h5E8);
    finish_frame(prev_done, 1'b0);
    // device never clocks: watchdog abort
    prev_done = done_cnt;
    prev_err = err_cnt;
    send(8'h42);
    t = 0;
    while (!kdata_drive_low && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("req_reached", kdata_drive_low, 1);
    t = 0;
    while (!err_timeout && t < 2500) begin
      @(negedge clk);
      t++;
    end
    check("timeout_cycles", t, 2000);
    check("abort_outputs", {kclk_drive_low, kdata_drive_low, done}, 3'b000);
    repeat (3) @(negedge clk);
    check("abort_err_count", err_cnt - prev_err, 1);
    check("abort_no_done", done_cnt - prev_done, 0);
    check("ready_after_abort", tx_ready, 1);
    // reset mid-frame after the fourth device clock
    prev_done = done_cnt;
    prev_err = err_cnt;
    send(PS2_CMD_SET_LED);
    dev_frame(1'b0, 4, 1'b0, bits);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_state", {kclk_drive_low, kdata_drive_low, tx_ready, busy}, 4'b0010);
    repeat (50) @(negedge clk);
    check("midreset_no_pulse", (done_cnt - prev_done) + (err_cnt - prev_err), 0);
    prev_done = done_cnt;
    send(PS2_CMD_RESET);
    dev_frame(1'b1, 11, 1'b0, bits);
    check("bits_ff", bits, 11'h7FE);
    finish_frame(prev_done, 1'b1);
    // clock glitch during data and a request while busy
    prev_done = done_cnt;
    send(PS2_CMD_SET_LED);
    @(negedge clk);
    tx_data = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    dev_frame(1'b1, 11, 1'b1, bits);
    check("bits_glitch", bits, 11'h7DA);
    finish_frame(prev_done, 1'b1);
    hits = 0;
    repeat (100) begin
      @(negedge clk);
      if (kclk_drive_low || busy) hits++;
    end
    check("no_queued_frame", hits, 0);
    check("single_frame", done_cnt - prev_done, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
